// File: rtl/epmp_pkg.sv
// Shared types for the EPMP return-stack controller: FSM states, requester IDs
// and the default stack depth.
package epmp_pkg;

   localparam int DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PUSH_SETUP = 2'd1,
      ST_PUSH       = 2'd2,
      ST_POP        = 2'd3
   } state_e;

   typedef enum logic {
      REQ_SEQ = 1'b0,
      REQ_IRQ = 1'b1
   } req_id_e;

   // Minimum counter width able to hold 0..depth inclusive.
   function automatic int cnt_w_for(input int depth);
      int w;
      w = 1;
      while ((1 << w) <= depth) w++;
      return w;
   endfunction

endpackage

// File: rtl/epmp_stack_depth.sv
// Saturating occupancy counter for the EPMP return stack with sticky Ovf/Udf.
// Optional high-water mark output when STACK_HWM_EN is defined.
module epmp_stack_depth
   import epmp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             do_push,
   input  logic             do_pop,
   input  logic             err_clr,
`ifdef STACK_HWM_EN
   output logic [CNT_W-1:0] hwm,
`endif
   output logic [CNT_W-1:0] depth,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             udf
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [CNT_W-1:0] depth_nxt;
   logic             ovf_set;
   logic             udf_set;

   assign full  = (depth == DEPTH_C);
   assign empty = (depth == '0);

   // A push while full still happens (stack drops its oldest entry), so only
   // the count saturates; a pop while empty never reaches the stack.
   always_comb begin
      depth_nxt = depth;
      ovf_set   = 1'b0;
      udf_set   = 1'b0;
      if (do_push) begin
         if (full) ovf_set = 1'b1;
         else      depth_nxt = depth + ONE_C;
      end else if (do_pop) begin
         if (empty) udf_set = 1'b1;
         else       depth_nxt = depth - ONE_C;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         depth <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         depth <= depth_nxt;
         ovf   <= (ovf & ~err_clr) | ovf_set;
         udf   <= (udf & ~err_clr) | udf_set;
      end
   end

`ifdef STACK_HWM_EN
   // Err_Clr restarts tracking from the occupancy as it stands after this cycle.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         hwm <= '0;
      end else if (err_clr || (depth_nxt > hwm)) begin
         hwm <= depth_nxt;
      end
   end
`endif

endmodule

// File: rtl/epmp_stack_ctrl.sv
// EPMP return-stack sequencer/arbiter: IRQ vs sequencer push/pop, IB strobes.
// Define STACK_HWM_EN to add the Hwm high-water-mark output.
module epmp_stack_ctrl
   import epmp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             Seq_Push_Req,
   input  logic             Seq_Pop_Req,
   input  logic             Irq_Push_Req,
   input  logic             Irq_Pop_Req,
   input  logic             Err_Clr,
   output logic             Seq_Ack,
   output logic             Irq_Ack,
   output logic             Push_Stack,
   output logic             Pop_Stack,
   output logic             Pc_Oe,
   output logic             Pc_Load,
   output logic [CNT_W-1:0] Depth,
   output logic             Full,
   output logic             Empty,
   output logic             Ovf,
`ifdef STACK_HWM_EN
   output logic [CNT_W-1:0] Hwm,
`endif
   output logic             Udf
);

   state_e  state, state_nxt;
   req_id_e gnt, gnt_nxt;

   logic seq_ack_nxt, irq_ack_nxt;
   logic push_nxt, pop_nxt, pc_oe_nxt, pc_load_nxt;

   // Entering POP decides the strobes now; an empty stack still gets an ack
   // but the stack and PC are left alone.
   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      seq_ack_nxt = 1'b0;
      irq_ack_nxt = 1'b0;
      push_nxt    = 1'b0;
      pop_nxt     = 1'b0;
      pc_oe_nxt   = 1'b0;
      pc_load_nxt = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (Irq_Push_Req) begin
               state_nxt = ST_PUSH_SETUP;
               gnt_nxt   = REQ_IRQ;
               pc_oe_nxt = 1'b1;
            end else if (Irq_Pop_Req) begin
               state_nxt   = ST_POP;
               gnt_nxt     = REQ_IRQ;
               irq_ack_nxt = 1'b1;
               pop_nxt     = ~Empty;
               pc_load_nxt = ~Empty;
            end else if (Seq_Push_Req) begin
               state_nxt = ST_PUSH_SETUP;
               gnt_nxt   = REQ_SEQ;
               pc_oe_nxt = 1'b1;
            end else if (Seq_Pop_Req) begin
               state_nxt   = ST_POP;
               gnt_nxt     = REQ_SEQ;
               seq_ack_nxt = 1'b1;
               pop_nxt     = ~Empty;
               pc_load_nxt = ~Empty;
            end
         end
         ST_PUSH_SETUP: begin
            state_nxt   = ST_PUSH;
            pc_oe_nxt   = 1'b1;
            push_nxt    = 1'b1;
            seq_ack_nxt = (gnt == REQ_SEQ);
            irq_ack_nxt = (gnt == REQ_IRQ);
         end
         ST_PUSH: state_nxt = ST_IDLE;
         ST_POP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state      <= ST_IDLE;
         gnt        <= REQ_SEQ;
         Seq_Ack    <= 1'b0;
         Irq_Ack    <= 1'b0;
         Push_Stack <= 1'b0;
         Pop_Stack  <= 1'b0;
         Pc_Oe      <= 1'b0;
         Pc_Load    <= 1'b0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         Seq_Ack    <= seq_ack_nxt;
         Irq_Ack    <= irq_ack_nxt;
         Push_Stack <= push_nxt;
         Pop_Stack  <= pop_nxt;
         Pc_Oe      <= pc_oe_nxt;
         Pc_Load    <= pc_load_nxt;
      end
   end

   epmp_stack_depth #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_depth (
      .clk     (clk),
      .nReset  (nReset),
      .do_push (state == ST_PUSH),
      .do_pop  (state == ST_POP),
      .err_clr (Err_Clr),
`ifdef STACK_HWM_EN
      .hwm     (Hwm),
`endif
      .depth   (Depth),
      .full    (Full),
      .empty   (Empty),
      .ovf     (Ovf),
      .udf     (Udf)
   );

endmodule

// File: doc/epmp_stack_ctrl.md
Name: epmp_stack_ctrl

Overview:
Sequencer and arbiter for the EPMP 4-deep hardware return stack. Two requesters share the stack: the instruction sequencer (CALL/RET) and the interrupt unit (entry/exit). The block generates Push_Stack/Pop_Stack and the IB bus-ownership strobes. It also tracks stack occupancy and flags overflow and underflow.

Parameters:
DEPTH, 4, number of stack entries; must match the stack instance.
CNT_W, 3, depth counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  in  1  system clock, rising edge.
nReset  in  1  asynchronous, active-low reset.
Seq_Push_Req  in  1  sequencer CALL request; level, held until ack.
Seq_Pop_Req  in  1  sequencer RET request; level, held until ack.
Seq_Ack  out  1  one-cycle acknowledge to the sequencer.
Irq_Push_Req  in  1  interrupt-entry request; level, held until ack.
Irq_Pop_Req  in  1  interrupt-return request; level, held until ack.
Irq_Ack  out  1  one-cycle acknowledge to the interrupt unit.
Push_Stack  out  1  to the stack: push IB into the stack this cycle.
Pop_Stack  out  1  to the stack: pop, and stack drives IB.
Pc_Oe  out  1  PC drives IBH/IBL (push data source).
Pc_Load  out  1  PC loads from IBH/IBL (pop data sink).
Depth  out  CNT_W  current occupancy, 0..DEPTH.
Full  out  1  Depth == DEPTH.
Empty  out  1  Depth == 0.
Ovf  out  1  sticky overflow flag.
Udf  out  1  sticky underflow flag.
Err_Clr  in  1  synchronous clear of Ovf/Udf.

Behaviour:
- Reset (nReset low, asynchronous): state IDLE. All strobes and acks are 0. Depth=0, Empty=1, Full=0, Ovf=0, Udf=0. Reset taken mid-operation abandons the operation with no ack.
- FSM states: IDLE, PUSH_SETUP, PUSH, POP.
- Arbitration in IDLE: Irq beats Seq. Within one requester, Push beats Pop if both are set; that combination is illegal, and the other request stays pending. Fixed priority is used, with no fairness.
- Push path: IDLE -> PUSH_SETUP (Pc_Oe=1) -> PUSH (Pc_Oe=1, Push_Stack=1, ack=1) -> IDLE. Latency from request to ack is 2 cycles. The setup cycle gives the tri-state IB a turnaround cycle.
- Pop path: IDLE -> POP (Pop_Stack=1, Pc_Load=1, ack=1) -> IDLE. Latency is 1 cycle.
- Requesters must drop the request in the cycle after ack. The FSM always returns to IDLE for at least one cycle between operations. Maximum throughput is therefore 1 push per 3 cycles or 1 pop per 2 cycles.
- The granted requester is latched on entry to PUSH_SETUP or POP. Requests arriving mid-operation do not pre-empt it.
- Depth update: +1 on PUSH cycle, saturating at DEPTH; -1 on POP cycle.
- Push when Full: the push is performed and the stack discards its oldest entry. Depth stays DEPTH and Ovf is set.
- Pop when Empty: the FSM still visits POP and acks, but Pop_Stack=0 and Pc_Load=0, so the PC is untouched. Depth stays 0 and Udf is set.
- Ovf/Udf are sticky until Err_Clr=1. If Err_Clr coincides with a new error in the same cycle, set wins.
- Pop_Stack and Push_Stack are never high together. Pc_Oe and Pop_Stack are never high together, to avoid bus contention.
- All outputs are registered, except Full/Empty, which decode Depth.

Optional Feature:
STACK_HWM_EN.
- Defined: adds output Hwm [CNT_W]. Hwm holds the maximum Depth reached since reset or since the last Err_Clr; it is reset to 0.
- Undefined: no Hwm port and no Hwm logic.

Decomposition:
- Shared package epmp_pkg:
  - FSM state enum.
  - Requester-ID encoding (REQ_SEQ, REQ_IRQ).
  - DEPTH_DEFAULT=4 constant.
- Natural sub-module epmp_stack_depth: the saturating up/down counter with Full/Empty/Ovf/Udf generation and the optional Hwm. The FSM and arbiter stay in the top module.

Test Plan:
1. Seq_Push_Req=1 from reset -> Pc_Oe high in cycles 1-2, Push_Stack and Seq_Ack in cycle 2. Depth=1, Empty=0.
2. 4 pushes then a 5th push -> Depth stays 4, Full=1, Ovf=1. Err_Clr then clears Ovf.
3. Seq_Pop_Req on empty stack -> Seq_Ack after 1 cycle, Pop_Stack=0, Pc_Load=0, Udf=1, Depth=0.
4. Seq_Push_Req and Irq_Push_Req raised in the same cycle -> Irq_Ack first. Seq_Ack follows 3 cycles later. Depth=2.
5. nReset asserted during PUSH_SETUP -> no ack, all strobes 0 immediately, Depth=0. After release, the held request is served normally.
6. With STACK_HWM_EN: push 3, pop 2, push 1 -> Hwm=3, Depth=2.
